// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready sequencer that decodes ALU opcodes into one-hot strobes, holds them for
// the op latency, captures the 64-bit result and updates HI/LO. Optional macro: ALU_SEQ_DIV0_TRAP_EN.
`default_nettype none

module alu_op_sequencer #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input  logic        clock,
   input  logic        clear_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [12:0] alu_ctl,
   input  logic [31:0] alu_chigh,
   input  logic [31:0] alu_clow,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_hi,
   output logic [31:0] rsp_lo,
   output logic        rsp_err,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q,
   output logic        busy
);

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHRA = 5'b00110;
   localparam logic [4:0] OP_SHL  = 5'b00111;
   localparam logic [4:0] OP_ROR  = 5'b01000;
   localparam logic [4:0] OP_ROL  = 5'b01001;
   localparam logic [4:0] OP_AND  = 5'b01010;
   localparam logic [4:0] OP_OR   = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   localparam logic [5:0] MUL_N = 6'(MUL_CYCLES);
   localparam logic [5:0] DIV_N = 6'(DIV_CYCLES);

   if (MUL_CYCLES < 1 || MUL_CYCLES > 63 || DIV_CYCLES < 1 || DIV_CYCLES > 63) begin : g_bad_cycles
      $error("alu_op_sequencer: MUL_CYCLES and DIV_CYCLES must lie in 1..63");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [4:0]  op_q;
   logic [5:0]  cnt;
   logic        req_legal;
   logic        div0_trap;
   logic        accept;
   logic        finish;

   // Zero result means an illegal opcode.
   function automatic logic [12:0] decode(input logic [4:0] op);
      logic [12:0] ctl;
      ctl = 13'd0;
      case (op)
         OP_ADD:  ctl[0]  = 1'b1;
         OP_SUB:  ctl[1]  = 1'b1;
         OP_MUL:  ctl[2]  = 1'b1;
         OP_DIV:  ctl[3]  = 1'b1;
         OP_AND:  ctl[4]  = 1'b1;
         OP_OR:   ctl[5]  = 1'b1;
         OP_SHR:  ctl[6]  = 1'b1;
         OP_SHRA: ctl[7]  = 1'b1;
         OP_SHL:  ctl[8]  = 1'b1;
         OP_ROR:  ctl[9]  = 1'b1;
         OP_ROL:  ctl[10] = 1'b1;
         OP_NEG:  ctl[11] = 1'b1;
         OP_NOT:  ctl[12] = 1'b1;
         default: ctl     = 13'd0;
      endcase
      return ctl;
   endfunction

`ifdef ALU_SEQ_DIV0_TRAP_EN
   assign div0_trap = (req_op == OP_DIV) && (req_b == 32'd0);
`else
   assign div0_trap = 1'b0;
`endif

   assign req_legal = (|decode(req_op)) && !div0_trap;
   assign accept    = (state == IDLE) && req_valid;
   assign finish    = (state == EXEC) && (cnt == 6'd1);

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      alu_ctl   = 13'd0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               state_nxt = req_legal ? EXEC : DONE;
            end
         end
         EXEC: begin
            alu_ctl = decode(op_q);
            if (cnt == 6'd1) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         op_q    <= 5'd0;
         alu_a   <= 32'd0;
         alu_b   <= 32'd0;
         cnt     <= 6'd0;
         rsp_hi  <= 32'd0;
         rsp_lo  <= 32'd0;
         rsp_err <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         if (accept) begin
            op_q  <= req_op;
            alu_a <= req_a;
            alu_b <= req_b;
            if (req_legal) begin
               cnt <= (req_op == OP_MUL) ? MUL_N : (req_op == OP_DIV) ? DIV_N : 6'd1;
            end else begin
               rsp_err <= 1'b1;
               rsp_hi  <= 32'd0;
               rsp_lo  <= 32'd0;
            end
         end
         if (state == EXEC) begin
            cnt <= cnt - 6'd1;
         end
         if (finish) begin
            rsp_hi  <= alu_chigh;
            rsp_lo  <= alu_clow;
            rsp_err <= 1'b0;
            // Only MUL/DIV are architecturally visible through HI/LO.
            if (op_q == OP_MUL || op_q == OP_DIV) begin
               hi_q <= alu_chigh;
               lo_q <= alu_clow;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: ALU stand-in, transaction-timed reference model with per-cycle compare,
// plus directed scenarios with literal expectations.
`default_nettype none

module tb_alu_op_sequencer;

   localparam int MUL_CYCLES = 4;
   localparam int DIV_CYCLES = 32;

   logic        clock = 1'b0;
   logic        clear_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_op = 5'd0;
   logic [31:0] req_a = 32'd0;
   logic [31:0] req_b = 32'd0;
   logic [31:0] alu_a, alu_b;
   logic [12:0] alu_ctl;
   logic [31:0] alu_chigh, alu_clow;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_hi, rsp_lo;
   logic        rsp_err;
   logic [31:0] hi_q, lo_q;
   logic        busy;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   alu_op_sequencer #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
      .clock(clock), .clear_n(clear_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_chigh(alu_chigh), .alu_clow(alu_clow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err),
      .hi_q(hi_q), .lo_q(lo_q), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Strobe bit index for each opcode, -1 if illegal.
   function automatic int op_bit(input logic [4:0] op);
      case (op)
         5'b00011: return 0;   5'b00100: return 1;   5'b01111: return 2;
         5'b10000: return 3;   5'b01010: return 4;   5'b01011: return 5;
         5'b00101: return 6;   5'b00110: return 7;   5'b00111: return 8;
         5'b01000: return 9;   5'b01001: return 10;  5'b10001: return 11;
         5'b10010: return 12;
         default:  return -1;
      endcase
   endfunction

   function automatic logic [4:0] code_of_bit(input int i);
      case (i)
         0: return 5'b00011;  1: return 5'b00100;  2: return 5'b01111;  3: return 5'b10000;
         4: return 5'b01010;  5: return 5'b01011;  6: return 5'b00101;  7: return 5'b00110;
         8: return 5'b00111;  9: return 5'b01000;  10: return 5'b01001; 11: return 5'b10001;
         default: return 5'b10010;
      endcase
   endfunction

   function automatic int latency(input logic [4:0] op);
      if (op == 5'b01111) return MUL_CYCLES;
      if (op == 5'b10000) return DIV_CYCLES;
      return 1;
   endfunction

   function automatic logic [63:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] s;
      longint      p;
      s = {27'd0, b[4:0]};
      case (op)
         5'b00011: return {32'd0, a + b};
         5'b00100: return {32'd0, a - b};
         5'b00101: return {32'd0, a >> s};
         5'b00110: return {32'd0, 32'($signed(a) >>> s)};
         5'b00111: return {32'd0, a << s};
         5'b01000: return {32'd0, (a >> s) | (a << (32 - s))};
         5'b01001: return {32'd0, (a << s) | (a >> (32 - s))};
         5'b01010: return {32'd0, a & b};
         5'b01011: return {32'd0, a | b};
         5'b01111: begin
            p = longint'($signed(a)) * longint'($signed(b));
            return 64'(p);
         end
         5'b10000: return (b == 32'd0) ? 64'hDEADBEEF_0BADF00D : {a % b, a / b};
         5'b10001: return {32'd0, -a};
         5'b10010: return {32'd0, ~a};
         default:  return 64'd0;
      endcase
   endfunction

   // ALU stand-in: keyed on the strobe the DUT raises.
   always_comb begin
      {alu_chigh, alu_clow} = 64'hBAD0BAD0_BAD0BAD0;
      for (int i = 0; i < 13; i++) begin
         if (alu_ctl == (13'd1 << i)) {alu_chigh, alu_clow} = ref_result(code_of_bit(i), alu_a, alu_b);
      end
   end

`ifdef ALU_SEQ_DIV0_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   // Reference model: timestamps each accepted request and its completion edge.
   longint      cyc = 0;
   longint      m_fin = 0;
   bit          m_exec = 0, m_done = 0, m_acc = 0;
   logic [4:0]  m_op = 0;
   logic [31:0] m_a = 0, m_b = 0, m_rhi = 0, m_rlo = 0, m_hi = 0, m_lo = 0;
   logic        m_err = 0;

   always @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         m_exec = 0; m_done = 0; m_acc = 0; m_op = 0; m_a = 0; m_b = 0;
         m_rhi = 0; m_rlo = 0; m_err = 0; m_hi = 0; m_lo = 0;
      end else begin
         logic [63:0] r;
         cyc++;
         m_acc = 0;
         if (m_exec) begin
            if (cyc == m_fin) begin
               r = ref_result(m_op, m_a, m_b);
               {m_rhi, m_rlo} = r;
               m_err = 0;
               if (m_op == 5'b01111 || m_op == 5'b10000) {m_hi, m_lo} = r;
               m_exec = 0;
               m_done = 1;
            end
         end else if (m_done) begin
            if (rsp_ready) m_done = 0;
         end else if (req_valid) begin
            m_acc = 1;
            m_op = req_op; m_a = req_a; m_b = req_b;
            if (op_bit(req_op) < 0 || (TRAP && req_op == 5'b10000 && req_b == 32'd0)) begin
               m_done = 1; m_err = 1; m_rhi = 0; m_rlo = 0;
            end else begin
               m_exec = 1;
               m_fin = cyc + latency(req_op);
            end
         end
      end
   end

   always @(negedge clock) begin
      if (cmp_en) begin
         logic [12:0] ectl;
         ectl = m_exec ? (13'd1 << op_bit(m_op)) : 13'd0;
         check("req_ready", req_ready, !m_exec && !m_done);
         check("busy", busy, m_exec || m_done);
         check("alu_ctl", alu_ctl, ectl);
         check("alu_a", alu_a, m_a);
         check("alu_b", alu_b, m_b);
         check("rsp_valid", rsp_valid, m_done);
         if (m_done) begin
            check("rsp_hi", rsp_hi, m_rhi);
            check("rsp_lo", rsp_lo, m_rlo);
            check("rsp_err", rsp_err, m_err);
         end
         check("hi_q", hi_q, m_hi);
         check("lo_q", lo_q, m_lo);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Returns 1 ns after the accepting edge, i.e. inside the first cycle after acceptance.
   task automatic do_req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      bit got;
      got = 0;
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      for (int i = 0; i < 200 && !got; i++) begin
         step();
         got = m_acc;
      end
      if (!got) check("req_accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
   endtask

   typedef struct { logic [4:0] op; logic [31:0] a; logic [31:0] b; } vec_t;
   vec_t vecs[$];

   initial begin
      int n;
      vecs = '{
         '{5'b00100, 32'd10, 32'd3},         '{5'b00101, 32'h80000000, 32'd4},
         '{5'b00110, 32'h80000000, 32'd4},   '{5'b00111, 32'd1, 32'd31},
         '{5'b01000, 32'd1, 32'd1},          '{5'b01001, 32'h80000001, 32'd4},
         '{5'b01010, 32'hF0F0F0F0, 32'hFF00FF00}, '{5'b01011, 32'h0000F000, 32'h0F000000},
         '{5'b10001, 32'd5, 32'd0},          '{5'b10010, 32'd0, 32'd0},
         '{5'b11111, 32'd1, 32'd2},          '{5'b01100, 32'd1, 32'd2},
         '{5'b00010, 32'd1, 32'd2},          '{5'b10000, 32'd100, 32'd7}
      };
      #2 clear_n = 1'b0;
      #1 cmp_en = 1'b1;
      #5;
      check("reset req_ready", req_ready, 1);
      check("reset rsp_valid", rsp_valid, 0);
      check("reset alu_ctl", alu_ctl, 0);
      check("reset hi_q", hi_q, 0);
      #14 clear_n = 1'b1;
      step();

      // ADD 5+7
      do_req(5'b00011, 32'd5, 32'd7);
      check("add ctl", alu_ctl, 13'h0001);
      check("add rsp_valid early", rsp_valid, 0);
      step();
      check("add ctl off", alu_ctl, 0);
      check("add rsp_valid", rsp_valid, 1);
      check("add rsp_lo", rsp_lo, 32'd12);
      check("add hi_q", hi_q, 0);
      step();

      // MUL 3 * -2
      do_req(5'b01111, 32'd3, 32'hFFFFFFFE);
      n = 0;
      for (int i = 1; i <= 5; i++) begin
         if (alu_ctl[2]) n++;
         if (i == 4) check("mul rsp_valid early", rsp_valid, 0);
         if (i < 5) step();
      end
      check("mul strobe cycles", n, MUL_CYCLES);
      check("mul rsp_valid", rsp_valid, 1);
      check("mul hi_q", hi_q, 32'hFFFFFFFF);
      check("mul lo_q", lo_q, 32'hFFFFFFFA);
      step();

      // Illegal opcode 00000
      do_req(5'b00000, 32'd9, 32'd9);
      check("ill rsp_valid", rsp_valid, 1);
      check("ill rsp_err", rsp_err, 1);
      check("ill rsp_lo", rsp_lo, 0);
      check("ill ctl", alu_ctl, 0);
      check("ill hi_q", hi_q, 32'hFFFFFFFF);
      step();

      // DIV by zero
      do_req(5'b10000, 32'd100, 32'd0);
`ifdef ALU_SEQ_DIV0_TRAP_EN
      check("div0 rsp_valid", rsp_valid, 1);
      check("div0 rsp_err", rsp_err, 1);
      check("div0 ctl", alu_ctl, 0);
      check("div0 hi_q", hi_q, 32'hFFFFFFFF);
`else
      n = 0;
      for (int i = 1; i <= DIV_CYCLES + 1; i++) begin
         if (alu_ctl[3]) n++;
         if (i <= DIV_CYCLES) step();
      end
      check("div0 strobe cycles", n, DIV_CYCLES);
      check("div0 rsp_err", rsp_err, 0);
      check("div0 hi_q", hi_q, 32'hDEADBEEF);
`endif
      step();

      // Table of remaining ops; the compare process checks every cycle.
      foreach (vecs[i]) do_req(vecs[i].op, vecs[i].a, vecs[i].b);
      for (int i = 0; i < DIV_CYCLES + 1; i++) step();
      check("div hi_q", hi_q, 32'd2);
      check("div lo_q", lo_q, 32'd14);
      step();

      // Response back-pressure with a queued request
      rsp_ready = 1'b0;
      do_req(5'b00011, 32'd1, 32'd2);
      req_valid = 1'b1; req_op = 5'b00100; req_a = 32'd10; req_b = 32'd3;
      step();
      for (int i = 0; i < 10; i++) begin
         check("bp rsp_valid", rsp_valid, 1);
         check("bp rsp_lo", rsp_lo, 32'd3);
         check("bp req_ready", req_ready, 0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      check("bp post rsp_valid", rsp_valid, 0);
      check("bp post busy", busy, 0);
      step();
      check("bp second busy", busy, 1);
      check("bp second ctl", alu_ctl, 13'h0002);
      req_valid = 1'b0;
      step();
      check("bp second rsp_lo", rsp_lo, 32'd7);
      step();

      // Reset during MUL EXEC cycle 2
      do_req(5'b01111, 32'd6, 32'd7);
      step();
      clear_n = 1'b0;
      #1;
      check("rst ctl", alu_ctl, 0);
      check("rst busy", busy, 0);
      check("rst rsp_valid", rsp_valid, 0);
      check("rst hi_q", hi_q, 0);
      #2 clear_n = 1'b1;
      step();
      check("rst req_ready", req_ready, 1);

      do_req(5'b00011, 32'd20, 32'd22);
      step();
      check("final rsp_lo", rsp_lo, 32'd42);
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
